// File: rtl/cost_port_arb.sv
// Two-lane round-robin arbiter for the shared W/J -> Cost lookup port.
// Issues eight lookups per granted burst and returns the costs tagged with lane and worker.
module cost_port_arb #(
  parameter int NW     = 8,
  parameter int COST_W = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic [3*NW-1:0]   perm0,
  input  logic [3*NW-1:0]   perm1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [2:0]        W,
  output logic [2:0]        J,
  input  logic [COST_W-1:0] Cost,
  output logic              cost_vld,
  output logic              cost_lane,
  output logic [2:0]        cost_idx,
  output logic [COST_W-1:0] cost_data,
  output logic              cost_last,
  busy
);

  // state | meaning
  // IDLE  | no burst in progress, arbitrating every cycle
  // ISSUE | driving lookup idx on W/J; re-arbitrates when idx is the last worker
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state;
  logic [2:0]      idx;
  logic            cur_lane;
  logic            rr;
  logic [3*NW-1:0] perm_q;

  logic            arb_en;
  logic            req_rr;
  logic            req_ot;
  logic            win_vld;
  logic            win_lane;
  logic [3*NW-1:0] win_perm;
  logic [2:0]      nxt_idx;
  logic [4:0]      jsel;

  logic            t1_vld;
  logic            t1_lane;
  logic [2:0]      t1_idx;

  assign arb_en   = (state == IDLE) || (idx == 3'(NW-1));
  assign req_rr   = rr ? req1 : req0;
  assign req_ot   = rr ? req0 : req1;
  assign win_vld  = arb_en && (req_rr || req_ot);
  assign win_lane = req_rr ? rr : ~rr;
  assign win_perm = win_lane ? perm1 : perm0;
  assign nxt_idx  = idx + 3'd1;
  assign jsel     = {2'b00, nxt_idx} + {1'b0, nxt_idx, 1'b0};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cur_lane <= 1'b0;
      rr       <= 1'b0;
      perm_q   <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      W        <= 3'd0;
      J        <= 3'd0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      if (win_vld) begin
        state    <= ISSUE;
        idx      <= 3'd0;
        cur_lane <= win_lane;
        perm_q   <= win_perm;
        rr       <= ~win_lane;
        gnt0     <= ~win_lane;
        gnt1     <= win_lane;
        busy     <= 1'b1;
        W        <= 3'd0;
        J        <= win_perm[2:0];
      end else if (state == ISSUE && idx != 3'(NW-1)) begin
        idx <= nxt_idx;
        W   <= nxt_idx;
        J   <= perm_q[jsel +: 3];
      end else begin
        state <= IDLE;
        idx   <= 3'd0;
        busy  <= 1'b0;
        W     <= 3'd0;
        J     <= 3'd0;
      end
    end
  end

  // The table answers one cycle after W/J, so the tag is delayed twice to meet its data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      t1_vld    <= 1'b0;
      t1_lane   <= 1'b0;
      t1_idx    <= 3'd0;
      cost_vld  <= 1'b0;
      cost_lane <= 1'b0;
      cost_idx  <= 3'd0;
      cost_data <= '0;
      cost_last <= 1'b0;
    end else begin
      t1_vld    <= (state == ISSUE);
      cost_vld  <= t1_vld;
      cost_last <= t1_vld && (t1_idx == 3'(NW-1));
      if (state == ISSUE) begin
        t1_lane <= cur_lane;
        t1_idx  <= idx;
      end
      if (t1_vld) begin
        cost_lane <= t1_lane;
        cost_idx  <= t1_idx;
        cost_data <= Cost;
      end
    end
  end

endmodule
